// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared operand-RAM geometry, requester count and arbiter state type.
package ram_arbiter_pkg;
    localparam int N_REQ  = 3;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 1188;
    typedef enum logic {FREE, LOCKED} state_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side handshake plus RAM port A signals of the operand-RAM arbiter.
interface ram_arbiter_if import ram_arbiter_pkg::*; #(
    parameter int N    = N_REQ,
    parameter int DATA = DATA_W,
    parameter int ADDR = ADDR_W
);
    logic [N-1:0]      req, wr, lock, gnt, rvalid;
    logic [N*ADDR-1:0] addr;
    logic [N*DATA-1:0] din;
    logic [DATA-1:0]   rdata, ram_din, ram_dout;
    logic [ADDR-1:0]   ram_addr;
    logic              ram_wr;
    modport slave (input req, wr, lock, addr, din, ram_dout,
                   output gnt, rvalid, rdata, ram_wr, ram_addr, ram_din);
    modport master (output req, wr, lock, addr, din, ram_dout,
                    input gnt, rvalid, rdata, ram_wr, ram_addr, ram_din);
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins.
module rr_pick #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);
    always_comb begin
        idx_o = '0;
        vld_o = |req_i;
        // scan backwards so the offset closest to ptr is the last one to land
        for (int k = N - 1; k >= 0; k--)
            if (req_i[(int'(ptr_i) + k) % N]) idx_o = PW'((int'(ptr_i) + k) % N);
        gnt_o = vld_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of operand-RAM port A with per-requester lock and read return.
module ram_arbiter import ram_arbiter_pkg::*; #(
    parameter int N    = N_REQ,
    parameter int DATA = DATA_W,
    parameter int ADDR = ADDR_W
) (
    input logic           clk,
    input logic           reset,
    ram_arbiter_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick_idx, win;
    logic [N-1:0]  rvalid_q, rvalid_d, pick_gnt, gnt;
    logic          pick_vld, hold;

    rr_pick #(.N(N)) u_pick (
        .req_i(bus.req),
        .ptr_i(ptr_q),
        .gnt_o(pick_gnt),
        .idx_o(pick_idx),
        .vld_o(pick_vld)
    );

    assign hold = state_q == LOCKED && bus.req[owner_q] && bus.lock[owner_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FREE;
            ptr_q    <= '0;
            owner_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
        end
    end

    // a released lock is arbitrated as FREE in the same cycle
    always_comb begin
        state_d  = (hold || (pick_vld && bus.lock[pick_idx])) ? LOCKED : FREE;
        owner_d  = hold ? owner_q : pick_idx;
        ptr_d    = (hold || !pick_vld) ? ptr_q : (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
        rvalid_d = gnt & ~bus.wr;
    end

    always_comb begin
        win          = hold ? owner_q : pick_idx;
        gnt          = reset ? '0 : hold ? (N'(1) << owner_q) : pick_gnt;
        bus.gnt      = gnt;
        bus.ram_wr   = |gnt & bus.wr[win];
        bus.ram_addr = |gnt ? bus.addr[int'(win) * ADDR +: ADDR] : '0;
        bus.ram_din  = |gnt ? bus.din[int'(win) * DATA +: DATA] : '0;
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = bus.ram_dout;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table, hand corner sequences and random traffic vs a reference model.
module tb_ram_arbiter;
    localparam int N = 3, DATA = 1188, ADDR = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.N(N), .DATA(DATA), .ADDR(ADDR)) bus();
    ram_arbiter #(.N(N), .DATA(DATA), .ADDR(ADDR)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DATA-1:0] ram [64];
    always @(posedge clk) begin
        if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= bus.ram_wr ? bus.ram_din : ram[bus.ram_addr];
    end

    int errors = 0, checks = 0;

    int              m_ptr = 0, m_owner = 0, g_cur = -1;
    bit              m_locked = 0;
    logic [N-1:0]    m_rv = '0;
    logic [DATA-1:0] m_rdata, shadow [64];
    logic [ADDR-1:0] ga;
    logic [DATA-1:0] gd;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_w(string n, logic [DATA-1:0] act, logic [DATA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ..%h expected ..%h at %0t", n, act[31:0], exp[31:0], $time);
        end
    endtask

    function automatic int model_pick();
        if (reset) return -1;
        if (m_locked && bus.req[m_owner] && bus.lock[m_owner]) return m_owner;
        for (int k = 0; k < N; k++)
            if (bus.req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_check();
        logic [N-1:0] eg;
        g_cur = model_pick();
        eg = '0;
        ga = '0;
        gd = '0;
        if (g_cur >= 0) begin
            eg[g_cur] = 1'b1;
            ga = bus.addr[g_cur*ADDR +: ADDR];
            gd = bus.din[g_cur*DATA +: DATA];
        end
        chk("gnt", bus.gnt, eg);
        chk("ram_wr", bus.ram_wr, (g_cur >= 0) ? bus.wr[g_cur] : 1'b0);
        chk("ram_addr", bus.ram_addr, ga);
        chk_w("ram_din", bus.ram_din, gd);
        chk("rvalid", bus.rvalid, m_rv);
        if (m_rv != 0) chk_w("rdata", bus.rdata, m_rdata);
    endtask

    task automatic model_update();
        bit hold;
        if (reset) begin
            m_ptr = 0;
            m_locked = 0;
            m_rv = '0;
        end else begin
            hold = m_locked && bus.req[m_owner] && bus.lock[m_owner];
            m_rv = '0;
            if (g_cur >= 0) begin
                if (bus.wr[g_cur]) shadow[ga] = gd;
                else begin
                    m_rv[g_cur] = 1'b1;
                    m_rdata = shadow[ga];
                end
                if (!hold) begin
                    m_ptr = (g_cur + 1) % N;
                    m_locked = bus.lock[g_cur];
                    m_owner = g_cur;
                end
            end else m_locked = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  req, wr, lock;
        logic [17:0] a;
        logic [11:0] d;
        logic [2:0]  eg, ev;
    } vec_t;
    vec_t tab [20];

    initial begin
        logic [DATA-1:0] pat;
        tab[0]  = '{1'b1, 3'b111, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b000, 3'b000};
        tab[1]  = '{1'b0, 3'b111, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b001, 3'b000};
        tab[2]  = '{1'b0, 3'b111, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b010, 3'b001};
        tab[3]  = '{1'b0, 3'b111, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b010};
        tab[4]  = '{1'b0, 3'b111, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b001, 3'b100};
        tab[5]  = '{1'b0, 3'b010, 3'b010, 3'b000, {6'd0, 6'd7, 6'd7}, 12'h5A5, 3'b010, 3'b001};
        tab[6]  = '{1'b0, 3'b001, 3'b000, 3'b000, {6'd0, 6'd7, 6'd7}, 12'h000, 3'b001, 3'b000};
        tab[7]  = '{1'b0, 3'b000, 3'b000, 3'b000, {6'd0, 6'd7, 6'd7}, 12'h000, 3'b000, 3'b001};
        tab[8]  = '{1'b0, 3'b100, 3'b000, 3'b100, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b000};
        tab[9]  = '{1'b0, 3'b111, 3'b000, 3'b100, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b100};
        tab[10] = '{1'b0, 3'b111, 3'b000, 3'b100, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b100};
        tab[11] = '{1'b0, 3'b111, 3'b000, 3'b100, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b100};
        tab[12] = '{1'b0, 3'b111, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b001, 3'b100};
        tab[13] = '{1'b0, 3'b100, 3'b000, 3'b100, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b001};
        tab[14] = '{1'b0, 3'b100, 3'b000, 3'b100, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b100};
        tab[15] = '{1'b1, 3'b111, 3'b000, 3'b100, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b000, 3'b100};
        tab[16] = '{1'b0, 3'b111, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b001, 3'b000};
        tab[17] = '{1'b0, 3'b000, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b000, 3'b001};
        tab[18] = '{1'b0, 3'b000, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b000, 3'b000};
        tab[19] = '{1'b0, 3'b100, 3'b000, 3'b000, {6'd3, 6'd2, 6'd1}, 12'h000, 3'b100, 3'b000};

        bus.req = '0;
        bus.wr = '0;
        bus.lock = '0;
        bus.addr = '0;
        bus.din = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 20; k++) begin
            reset = tab[k].rst;
            bus.req = tab[k].req;
            bus.wr = tab[k].wr;
            bus.lock = tab[k].lock;
            bus.addr = tab[k].a;
            bus.din = {DATA'(tab[k].d), DATA'(tab[k].d), DATA'(tab[k].d)};
            @(negedge clk);
            chk($sformatf("tab%0d_gnt", k), bus.gnt, tab[k].eg);
            chk($sformatf("tab%0d_rvalid", k), bus.rvalid, tab[k].ev);
            if (k == 7) chk("rdata_5a5", bus.rdata[11:0], 12'h5A5);
            if (k == 18) begin
                chk("idle_ram_wr", bus.ram_wr, 1'b0);
                chk("idle_ram_addr", bus.ram_addr, 6'd0);
            end
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        // a write granted just before reset must still reach the RAM
        for (int b = 0; b < DATA; b += 12) pat[b +: 12] = 12'($urandom);
        reset = 1'b0;
        bus.lock = '0;
        bus.req = 3'b001;
        bus.wr = 3'b001;
        bus.addr = {6'd0, 6'd0, 6'd20};
        bus.din = {{(2*DATA){1'b0}}, pat};
        cycle();
        reset = 1'b1;
        bus.req = '0;
        bus.wr = '0;
        cycle();
        reset = 1'b0;
        bus.req = 3'b001;
        cycle();
        bus.req = '0;
        @(negedge clk);
        chk("wr_before_reset_rvalid", bus.rvalid, 3'b001);
        chk_w("wr_before_reset_rdata", bus.rdata, pat);
        @(posedge clk);
        #1;
        m_rv = '0;

        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            bus.req = 3'($urandom);
            bus.wr = 3'($urandom);
            bus.lock = 3'($urandom) & 3'($urandom) | 3'($urandom) & 3'($urandom);
            for (int i = 0; i < N; i++) bus.addr[i*ADDR +: ADDR] = ADDR'($urandom_range(0, 7));
            for (int b = 0; b < N*DATA; b += 12) bus.din[b +: 12] = 12'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares port A of the dual-port operand RAM (1188-bit words, 64 entries) among up to N requesters: the pairing sequencer, the host loader and the host readback engine. Each cycle it grants at most one request by round-robin, with an optional lock for multi-cycle sequences. It drives the RAM port combinationally and routes the 1-cycle-late read data back to the granted requester with a per-requester valid strobe. It sits between the requesters and the RAM. Port B is unaffected.

## Interface
- `N`, default 3: number of requesters; requester 0 wins ties after reset.
- `DATA`, default 1188: RAM word width.
- `ADDR`, default 6: RAM address width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N  per-requester access request, level.
- `wr`  in  N  per-requester write enable; qualified by `req`.
- `lock`  in  N  per-requester hold-grant request.
- `addr`  in  N*ADDR  packed addresses; requester i uses bits [i*ADDR +: ADDR].
- `din`  in  N*DATA  packed write data, same packing.
- `gnt`  out  N  one-hot grant, combinational, this cycle.
- `rvalid`  out  N  one-hot, registered; `rdata` is valid for requester i.
- `rdata`  out  DATA  read data, equal to `ram_dout`.
- `ram_wr`  out  1  RAM port A write enable.
- `ram_addr`  out  ADDR  RAM port A address.
- `ram_din`  out  DATA  RAM port A write data.
- `ram_dout`  in  DATA  RAM port A read data, 1-cycle latency.

## Operation
- State: `ptr` (0..N-1, round-robin start), `owner_vld`, `owner` (0..N-1), `rvalid` register.
- Reset values: `ptr`=0, `owner_vld`=0, `rvalid`=0.
- While `reset`=1, `gnt` is forced to 0 and `ram_wr` to 0.
- States:
  - FREE (`owner_vld`=0).
  - LOCKED (`owner_vld`=1).
- FREE behaviour:
  - The winner is the first i with `req[i]`=1, scanning ptr, ptr+1, … modulo N.
  - After a grant to i: `ptr` ← (i+1) mod N.
  - If `lock[i]`=1 at the grant: go to LOCKED with `owner`←i; `ptr` is still advanced.
- LOCKED behaviour:
  - Only `owner` can be granted; every other `req` is stalled with `gnt`=0.
  - Stay LOCKED while `req[owner]` & `lock[owner]`.
  - If either drops, return to FREE at the next edge. The same cycle is arbitrated as FREE, so owner releases and other requests win immediately. `ptr` is unchanged by a release.
- Mux:
  - With grant to i: `ram_addr`=addr_i, `ram_din`=din_i, `ram_wr`=`wr[i]`.
  - With no grant: `ram_addr`=0, `ram_din`=0, `ram_wr`=0.
- Read return:
  - `rvalid[i]` ← `gnt[i]` & ~`wr[i]`.
  - Writes never raise `rvalid`, even though the RAM echoes the write data on its output.
- Requesters hold `req`/`addr`/`din`/`wr` stable until they see `gnt`; an un-granted request is simply retried.
- `lock` without `req` is ignored.

## Timing
- Grant is zero-latency: `gnt` is combinational from `req`, `lock` and registered state.
- A write lands in the RAM at the edge ending the granted cycle.
- Read data appears with `rvalid` exactly one cycle after the granted cycle.
- Back-to-back grants to one requester are allowed every cycle. Throughput is 1 access per cycle.
- Round-robin fairness: with all N requesting and no locks, each requester is granted exactly once in every N consecutive cycles.
- Reset in LOCKED returns to FREE. `rvalid` of an in-flight read is cleared (the read is lost; the requester must reissue).
- A requester granted in the last cycle before `reset` still sees its write committed in the RAM.

## Structure
- Shared header: `ADDR`/`DATA` defaults and the `N_REQ` constant, reused by the sequencer and the host loader.
- One sub-module: `rr_pick`, a combinational N-way round-robin priority picker. Inputs: request vector and `ptr`. Outputs: one-hot grant and winner index.
- The arbiter holds the lock FSM, the muxes and the `rvalid` register.

## Test plan
- After reset, `req`=3'b111, no lock, all reads → `gnt` sequence 001, 010, 100, 001… Each `rvalid` bit follows its `gnt` bit 1 cycle later.
- Requester 1 writes 0x5A5 to address 7; next cycle requester 0 reads address 7 → `rvalid`=001 one cycle later, `rdata`=0x5A5. The write cycle produces no `rvalid`.
- Requester 2 takes the lock for 4 cycles while requesters 0 and 1 request → `gnt`=100 for 4 cycles. `lock` drops on the 5th cycle → requester 0 is granted that same cycle.
- `reset` asserted while locked with a read in flight → next cycle `rvalid`=0, state FREE, `gnt`=001 when `req`=3'b111.
- No `req` → `gnt`=0, `ram_wr`=0, `ram_addr`=0, `rvalid`=0. Then `req`=3'b100 alone → `gnt`=100 that same cycle, whatever `ptr` is.
